// File: rtl/video_mon_pkg.sv
// Shared types for the AXI4-Stream video monitor: FSM states and err_o bit positions.
package video_mon_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    IN_FRAME = 2'd2
  } mon_state_t;

  localparam int unsigned ERR_W         = 4;
  localparam int unsigned ERR_EARLY_SOF = 0;
  localparam int unsigned ERR_TRUNC     = 1;
  localparam int unsigned ERR_OVERFLOW  = 2;
  localparam int unsigned ERR_MISMATCH  = 3;

endpackage

// File: rtl/video_mon_sat_cnt.sv
// Saturating up-counter; clr together with inc loads 1 so a new frame/line can start on the same beat.
module video_mon_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         at_max
);

  assign at_max = &q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc && !at_max) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/video_stream_monitor.sv
// Passive AXI4-Stream video monitor: per-frame beat/line/period statistics and sticky error flags.
// Optional min/max line tracking and line-length mismatch check under `VIDEO_MON_LINE_CHECK_EN.
module video_stream_monitor
  import video_mon_pkg::*;
#(
  parameter int unsigned FCNT_W       = 8,
  parameter int unsigned FLEN_W       = 24,
  parameter int unsigned LINE_W       = 12,
  parameter int unsigned PIX_W        = 12,
  parameter int unsigned PERIOD_W     = 32,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                TVALID,
  input  logic                TREADY,
  input  logic                TUSER,
  input  logic                TLAST,
  input  logic                meas_en_i,
  input  logic                err_clr_i,
  output logic [FCNT_W-1:0]   frames_cnt_o,
  output logic [FLEN_W-1:0]   frame_len_o,
  output logic [LINE_W-1:0]   lines_cnt_o,
  output logic [PIX_W-1:0]    pixel_cnt_o,
  output logic [PERIOD_W-1:0] frame_period_o,
  output logic                frame_done_o,
  output logic                timeout_o,
  output logic [ERR_W-1:0]    err_o,
  output logic [PIX_W-1:0]    min_line_o,
  output logic [PIX_W-1:0]    max_line_o
);

  localparam int unsigned TO_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = (IDLE_TIMEOUT == 0) ? '0 : TO_W'(IDLE_TIMEOUT - 1);
  localparam bit TO_EN = (IDLE_TIMEOUT != 0);

  mon_state_t state, state_nxt;

  logic beat, sof;
  logic act, open, commit_sof, commit_to, commit, run_beat;
  logic timeout_hit, line_done, mismatch;
  logic [TO_W-1:0]     idle_cnt;
  logic [FLEN_W-1:0]   flen_q;
  logic [LINE_W-1:0]   lines_q;
  logic [PIX_W-1:0]    line_q, line_next, done_len;
  logic [PERIOD_W-1:0] period_q;
  logic flen_max, lines_max, line_max, period_max;
  logic [ERR_W-1:0]    err_set;

  assign beat = TVALID & TREADY;
  assign sof  = beat & TUSER;

  // State register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; dropping the enable always returns to IDLE
  always_comb begin
    state_nxt = state;
    if (!meas_en_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     state_nxt = WAIT_SOF;
        WAIT_SOF: if (sof) state_nxt = IN_FRAME;
        IN_FRAME: if (commit_to) state_nxt = WAIT_SOF;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Per-cycle decode; open marks the beat that becomes beat 1 of a new frame
  always_comb begin
    act        = 1'b0;
    open       = 1'b0;
    commit_sof = 1'b0;
    commit_to  = 1'b0;
    run_beat   = 1'b0;
    if (meas_en_i) begin
      case (state)
        WAIT_SOF: open = sof;
        IN_FRAME: begin
          act        = 1'b1;
          open       = sof;
          commit_sof = sof;
          commit_to  = timeout_hit;
          run_beat   = beat & ~TUSER;
        end
        default: ;
      endcase
    end
  end

  assign commit      = commit_sof | commit_to;
  assign timeout_hit = TO_EN && !beat && (flen_q != '0) && (idle_cnt == TO_LAST);
  assign line_done   = (open | run_beat) & TLAST;
  assign line_next   = line_max ? line_q : line_q + PIX_W'(1);
  assign done_len    = open ? PIX_W'(1) : line_next;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                 idle_cnt <= '0;
    else if (!act || beat)        idle_cnt <= '0;
    else if (idle_cnt != TO_LAST) idle_cnt <= idle_cnt + TO_W'(1);
  end

  video_mon_sat_cnt #(.W(FLEN_W)) u_flen (
    .clk(ACLK), .rst_n(ARESETn),
    .clr(~act | commit_sof), .inc(open | run_beat),
    .q(flen_q), .at_max(flen_max)
  );

  video_mon_sat_cnt #(.W(LINE_W)) u_lines (
    .clk(ACLK), .rst_n(ARESETn),
    .clr(~act | commit_sof), .inc(line_done),
    .q(lines_q), .at_max(lines_max)
  );

  video_mon_sat_cnt #(.W(PIX_W)) u_line_len (
    .clk(ACLK), .rst_n(ARESETn),
    .clr(~act | commit_sof | (run_beat & TLAST)), .inc((open | run_beat) & ~TLAST),
    .q(line_q), .at_max(line_max)
  );

  video_mon_sat_cnt #(.W(PERIOD_W)) u_period (
    .clk(ACLK), .rst_n(ARESETn),
    .clr(~act | commit_sof), .inc(act | open),
    .q(period_q), .at_max(period_max)
  );

  always_comb begin
    err_set                = '0;
    err_set[ERR_EARLY_SOF] = commit_sof & (lines_q == '0);
    err_set[ERR_TRUNC]     = commit & (line_q != '0);
    err_set[ERR_OVERFLOW]  = act & (flen_max | lines_max | line_max | period_max);
    err_set[ERR_MISMATCH]  = mismatch;
  end

  // Committed statistics and sticky errors; a set in the same cycle beats a clear
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      frames_cnt_o   <= '0;
      frame_len_o    <= '0;
      lines_cnt_o    <= '0;
      pixel_cnt_o    <= '0;
      frame_period_o <= '0;
      frame_done_o   <= 1'b0;
      timeout_o      <= 1'b0;
      err_o          <= '0;
    end else begin
      frame_done_o <= commit;
      if (state == IDLE)  frames_cnt_o <= '0;
      else if (commit)    frames_cnt_o <= frames_cnt_o + FCNT_W'(1);
      if (commit) begin
        frame_len_o <= flen_q;
        lines_cnt_o <= lines_q;
        timeout_o   <= commit_to;
      end
      if (commit_sof) frame_period_o <= period_q;
      if (line_done)  pixel_cnt_o    <= done_len;
      err_o <= (err_o & ~{ERR_W{err_clr_i}}) | err_set;
    end
  end

`ifdef VIDEO_MON_LINE_CHECK_EN
  logic [PIX_W-1:0] run_min, run_max, first_len;
  logic             first_line;

  assign first_line = open | (lines_q == '0);
  assign mismatch   = line_done & ~first_line & (done_len != first_len);

  // Running min/max of the open frame, published on commit
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      run_min    <= '0;
      run_max    <= '0;
      first_len  <= '0;
      min_line_o <= '0;
      max_line_o <= '0;
    end else begin
      if (commit) begin
        min_line_o <= run_min;
        max_line_o <= run_max;
      end
      if (line_done && first_line) begin
        run_min   <= done_len;
        run_max   <= done_len;
        first_len <= done_len;
      end else if (line_done) begin
        if (done_len < run_min) run_min <= done_len;
        if (done_len > run_max) run_max <= done_len;
      end else if (!act || open) begin
        run_min   <= '0;
        run_max   <= '0;
        first_len <= '0;
      end
    end
  end
`else
  assign mismatch   = 1'b0;
  assign min_line_o = '0;
  assign max_line_o = '0;
`endif

endmodule

// File: tb/tb_video_stream_monitor.sv
// Directed self-checking bench for video_stream_monitor (PIX_W=4, IDLE_TIMEOUT=16).
module tb_video_stream_monitor;

  localparam int unsigned FCNT_W   = 8;
  localparam int unsigned FLEN_W   = 24;
  localparam int unsigned LINE_W   = 12;
  localparam int unsigned PIX_W    = 4;
  localparam int unsigned PERIOD_W = 32;

  logic clk = 1'b0;
  logic rst_n, tvalid, tready, tuser, tlast, meas_en, err_clr;
  logic [FCNT_W-1:0]   frames_cnt;
  logic [FLEN_W-1:0]   frame_len;
  logic [LINE_W-1:0]   lines_cnt;
  logic [PIX_W-1:0]    pixel_cnt;
  logic [PERIOD_W-1:0] frame_period;
  logic                frame_done, timeout;
  logic [3:0]          err;
  logic [PIX_W-1:0]    min_line, max_line;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int unsigned cyc = 0;
  int unsigned last_sof_cyc = 0;

  video_stream_monitor #(
    .FCNT_W(FCNT_W), .FLEN_W(FLEN_W), .LINE_W(LINE_W), .PIX_W(PIX_W),
    .PERIOD_W(PERIOD_W), .IDLE_TIMEOUT(16)
  ) dut (
    .ACLK(clk), .ARESETn(rst_n), .TVALID(tvalid), .TREADY(tready), .TUSER(tuser),
    .TLAST(tlast), .meas_en_i(meas_en), .err_clr_i(err_clr),
    .frames_cnt_o(frames_cnt), .frame_len_o(frame_len), .lines_cnt_o(lines_cnt),
    .pixel_cnt_o(pixel_cnt), .frame_period_o(frame_period), .frame_done_o(frame_done),
    .timeout_o(timeout), .err_o(err), .min_line_o(min_line), .max_line_o(max_line)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Holds one beat until it is handshaken; stall randomises TREADY (at most 4 refusals)
  task automatic send_beat(input bit sof, input bit last, input bit stall);
    bit acc;
    int waits = 0;
    tvalid = 1'b1;
    tuser  = sof;
    tlast  = last;
    do begin
      tready = (stall && waits < 4) ? ($urandom_range(0, 2) != 0) : 1'b1;
      acc = tready;
      step();
      waits++;
    end while (!acc);
    if (sof) last_sof_cyc = cyc;
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
    tready = 1'b1;
  endtask

  task automatic send_line(input int len, input bit sof, input bit stall);
    for (int p = 0; p < len; p++) send_beat(sof && p == 0, p == len - 1, stall);
  endtask

  task automatic send_frame(input int nlines, input int len, input bit stall);
    for (int l = 0; l < nlines; l++) send_line(len, l == 0, stall);
  endtask

  task automatic restart();
    meas_en = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    meas_en = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (frames_cnt !== 8'd0) begin errors++; $display("FAIL reset_frames: got %0d want 0", frames_cnt); end
    checks++; if (frame_len !== 24'd0) begin errors++; $display("FAIL reset_frame_len: got %0d want 0", frame_len); end
    checks++; if ({lines_cnt, pixel_cnt} !== 16'd0) begin errors++; $display("FAIL reset_lines_pixel: got %0d/%0d want 0/0", lines_cnt, pixel_cnt); end
    checks++; if (frame_period !== 32'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", frame_period); end
    checks++; if ({frame_done, timeout, err} !== 6'd0) begin errors++; $display("FAIL reset_flags: got done=%0b to=%0b err=%b want 0", frame_done, timeout, err); end
    rst_n = 1'b1;
    meas_en = 1'b1;
    step();
    step();
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    repeat (3) send_frame(4, 8, 1'b0);
    checks++; if (frames_cnt !== 8'd2) begin errors++; $display("FAIL basic_frames: got %0d want 2", frames_cnt); end
    checks++; if (frame_len !== 24'd32) begin errors++; $display("FAIL basic_frame_len: got %0d want 32", frame_len); end
    checks++; if (lines_cnt !== 12'd4) begin errors++; $display("FAIL basic_lines: got %0d want 4", lines_cnt); end
    checks++; if (pixel_cnt !== 4'd8) begin errors++; $display("FAIL basic_pixel: got %0d want 8", pixel_cnt); end
    checks++; if (frame_period !== 32'd32) begin errors++; $display("FAIL basic_period: got %0d want 32", frame_period); end
    checks++; if ({timeout, err} !== 5'd0) begin errors++; $display("FAIL basic_flags: got to=%0b err=%b want 0", timeout, err); end
    step();
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL basic_done_pulses: got %0d want 2", done_cnt - d0); end
  endtask

  // Continues from test_basic: one idle cycle has already elapsed since the last beat
  task automatic test_timeout();
    int d0;
    repeat (14) step();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL timeout_early: got done=%0b want 0 after 15 idle", frame_done); end
    step();
    checks++; if ({frame_done, timeout} !== 2'b11) begin errors++; $display("FAIL timeout_commit: got done=%0b to=%0b want 1/1", frame_done, timeout); end
    checks++; if (frames_cnt !== 8'd3) begin errors++; $display("FAIL timeout_frames: got %0d want 3", frames_cnt); end
    checks++; if (frame_len !== 24'd32) begin errors++; $display("FAIL timeout_frame_len: got %0d want 32", frame_len); end
    checks++; if (frame_period !== 32'd32) begin errors++; $display("FAIL timeout_period_held: got %0d want 32", frame_period); end
    step();
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) send_beat(1'b0, i == 4, 1'b0);
    repeat (20) step();
    checks++; if (pixel_cnt !== 4'd8) begin errors++; $display("FAIL wait_sof_ignores: got pixel %0d want 8", pixel_cnt); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL wait_sof_no_commit: got %0d pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_stall();
    int unsigned c1;
    restart();
    checks++; if (frames_cnt !== 8'd0) begin errors++; $display("FAIL idle_clears_frames: got %0d want 0", frames_cnt); end
    send_frame(8, 8, 1'b1);
    c1 = last_sof_cyc;
    send_beat(1'b1, 1'b0, 1'b1);
    checks++; if (frame_len !== 24'd64) begin errors++; $display("FAIL stall_frame_len: got %0d want 64", frame_len); end
    checks++; if (lines_cnt !== 12'd8) begin errors++; $display("FAIL stall_lines: got %0d want 8", lines_cnt); end
    checks++; if (frame_period !== 32'(last_sof_cyc - c1)) begin errors++; $display("FAIL stall_period: got %0d want %0d", frame_period, last_sof_cyc - c1); end
    checks++; if (frames_cnt !== 8'd1) begin errors++; $display("FAIL stall_frames: got %0d want 1", frames_cnt); end
  endtask

  task automatic test_errors();
    restart();
    send_beat(1'b1, 1'b0, 1'b0);
    repeat (4) send_beat(1'b0, 1'b0, 1'b0);
    send_beat(1'b1, 1'b0, 1'b0);
    checks++; if (err !== 4'b0011) begin errors++; $display("FAIL early_trunc_err: got %b want 0011", err); end
    checks++; if ({frame_len, lines_cnt} !== {24'd5, 12'd0}) begin errors++; $display("FAIL early_stats: got len=%0d lines=%0d want 5/0", frame_len, lines_cnt); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++; if (err !== 4'b0000) begin errors++; $display("FAIL err_clear1: got %b want 0000", err); end
    for (int i = 0; i < 7; i++) send_beat(1'b0, i == 6, 1'b0);
    repeat (3) send_beat(1'b0, 1'b0, 1'b0);
    send_beat(1'b1, 1'b0, 1'b0);
    checks++; if (err !== 4'b0010) begin errors++; $display("FAIL trunc_err: got %b want 0010", err); end
    checks++; if ({frame_len, lines_cnt} !== {24'd11, 12'd1}) begin errors++; $display("FAIL trunc_stats: got len=%0d lines=%0d want 11/1", frame_len, lines_cnt); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++; if (err !== 4'b0000) begin errors++; $display("FAIL err_clear2: got %b want 0000", err); end
    repeat (2) send_beat(1'b0, 1'b0, 1'b0);
    err_clr = 1'b1;
    send_beat(1'b1, 1'b0, 1'b0);
    err_clr = 1'b0;
    checks++; if (err !== 4'b0011) begin errors++; $display("FAIL set_beats_clear: got %b want 0011", err); end
    checks++; if (frame_len !== 24'd3) begin errors++; $display("FAIL set_beats_clear_len: got %0d want 3", frame_len); end
  endtask

  task automatic test_overflow();
    restart();
    send_frame(2, 20, 1'b0);
    checks++; if (pixel_cnt !== 4'd15) begin errors++; $display("FAIL ovf_pixel: got %0d want 15", pixel_cnt); end
    checks++; if (err[2] !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want bit2 set", err); end
    send_beat(1'b1, 1'b0, 1'b0);
    checks++; if ({frame_len, lines_cnt} !== {24'd40, 12'd2}) begin errors++; $display("FAIL ovf_stats: got len=%0d lines=%0d want 40/2", frame_len, lines_cnt); end
`ifdef VIDEO_MON_LINE_CHECK_EN
    checks++; if ({min_line, max_line} !== {4'd15, 4'd15}) begin errors++; $display("FAIL ovf_minmax: got %0d/%0d want 15/15", min_line, max_line); end
`endif
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++; if (err !== 4'b0000) begin errors++; $display("FAIL ovf_clear: got %b want 0000", err); end
  endtask

  task automatic test_line_check();
    restart();
    send_line(8, 1'b1, 1'b0);
    send_line(8, 1'b0, 1'b0);
    send_line(7, 1'b0, 1'b0);
    checks++; if (pixel_cnt !== 4'd7) begin errors++; $display("FAIL lc_pixel: got %0d want 7", pixel_cnt); end
    send_beat(1'b1, 1'b0, 1'b0);
    checks++; if ({frame_len, lines_cnt} !== {24'd23, 12'd3}) begin errors++; $display("FAIL lc_stats: got len=%0d lines=%0d want 23/3", frame_len, lines_cnt); end
`ifdef VIDEO_MON_LINE_CHECK_EN
    checks++; if (err !== 4'b1000) begin errors++; $display("FAIL lc_mismatch: got %b want 1000", err); end
    checks++; if ({min_line, max_line} !== {4'd7, 4'd8}) begin errors++; $display("FAIL lc_minmax: got %0d/%0d want 7/8", min_line, max_line); end
`else
    checks++; if (err !== 4'b0000) begin errors++; $display("FAIL lc_no_mismatch: got %b want 0000", err); end
    checks++; if ({min_line, max_line} !== 8'd0) begin errors++; $display("FAIL lc_minmax_off: got %0d/%0d want 0/0", min_line, max_line); end
`endif
  endtask

  task automatic test_wrap();
    int d0;
    restart();
    d0 = done_cnt;
    repeat (257) send_beat(1'b1, 1'b1, 1'b0);
    step();
    checks++; if (frames_cnt !== 8'd0) begin errors++; $display("FAIL wrap_frames: got %0d want 0", frames_cnt); end
    checks++; if (done_cnt - d0 !== 256) begin errors++; $display("FAIL wrap_done: got %0d want 256", done_cnt - d0); end
    checks++; if ({frame_len, lines_cnt, pixel_cnt} !== {24'd1, 12'd1, 4'd1}) begin errors++; $display("FAIL wrap_stats: got %0d/%0d/%0d want 1/1/1", frame_len, lines_cnt, pixel_cnt); end
    checks++; if ({frame_period, err} !== {32'd1, 4'd0}) begin errors++; $display("FAIL wrap_period_err: got %0d/%b want 1/0000", frame_period, err); end
  endtask

  task automatic test_reset_mid();
    int d0;
    send_line(8, 1'b1, 1'b0);
    repeat (2) send_beat(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    checks++; if ({frames_cnt, frame_len, pixel_cnt} !== 36'd0) begin errors++; $display("FAIL midreset_async: got %0d/%0d/%0d want 0", frames_cnt, frame_len, pixel_cnt); end
    checks++; if (frame_period !== 32'd0) begin errors++; $display("FAIL midreset_period: got %0d want 0", frame_period); end
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    d0 = done_cnt;
    send_frame(4, 8, 1'b0);
    send_beat(1'b1, 1'b0, 1'b0);
    step();
    checks++; if ({frames_cnt, frame_len} !== {8'd1, 24'd32}) begin errors++; $display("FAIL midreset_fresh: got %0d/%0d want 1/32", frames_cnt, frame_len); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL midreset_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_enable_drop();
    int d0;
    repeat (9) send_beat(1'b0, 1'b0, 1'b0);
    d0 = done_cnt;
    meas_en = 1'b0;
    repeat (3) step();
    checks++; if (frames_cnt !== 8'd0) begin errors++; $display("FAIL endrop_frames: got %0d want 0", frames_cnt); end
    checks++; if ({frame_len, lines_cnt} !== {24'd32, 12'd4}) begin errors++; $display("FAIL endrop_hold: got %0d/%0d want 32/4", frame_len, lines_cnt); end
    meas_en = 1'b1;
    step();
    step();
    send_beat(1'b1, 1'b0, 1'b0);
    step();
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL endrop_no_done: got %0d want 0", done_cnt - d0); end
    checks++; if (frames_cnt !== 8'd0) begin errors++; $display("FAIL endrop_first_sof: got %0d want 0", frames_cnt); end
  endtask

  initial begin
    rst_n   = 1'b0;
    tvalid  = 1'b0;
    tready  = 1'b1;
    tuser   = 1'b0;
    tlast   = 1'b0;
    meas_en = 1'b0;
    err_clr = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_stall();
    test_errors();
    test_overflow();
    test_line_check();
    test_wrap();
    test_reset_mid();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
